rio_mux_input: RTL
==================

// Module: rio_mux_input
// PURPOSE
//  Parametrised successor of the top-level multiplexed-input slot: time-shares NUM_CH slow
//  status values (temps, valid flags, ...) over one VAL_W value + ID_W id field of the tx frame.
//  Also owns the interface sync edge detector and the interface-timeout watchdog that drives ERROR.
//  Sits between the interface block (sync output) and the tx_data frame assembly in rio.
// PARAMETERS
//  NUM_CH   2        number of multiplexed channels (1..2**ID_W)
//  VAL_W    16       width of each channel value and of mux_value
//  ID_W     8        width of mux_id
//  TIMEOUT  2700000  clk cycles without a sync rising edge before timeout asserts
// PORTS
//  clk         in   1            system clock
//  rst         in   1            synchronous active-high reset
//  sync        in   1            raw frame-sync from interface (async to clk)
//  ch_values   in   NUM_CH*VAL_W channel c at [c*VAL_W +: VAL_W], zero-extended by caller
//  sync_rise   out  1            one-cycle pulse per sync rising edge
//  mux_value   out  VAL_W        value of channel mux_id, frame-consistent
//  mux_id      out  ID_W         channel index currently carried
//  timeout     out  1            interface timeout (ERROR source)
//  frame_cnt   out  16           sync rising edges since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): sync shift reg=0, sync_rise=0, mux_value=0, mux_id=0, timeout=0,
//    frame_cnt=0, wd counter=0, rr pointer=0. rst wins over every simultaneous event.
//  - Edge detect: 3-bit shift reg sync_r<={sync_r[1:0],sync}; sync_rise registered from
//    sync_r[2:1]==2'b01; first clk sampling sync=1 -> sync_rise high 3 cycles later, 1 cycle wide.
//  - Mux: on edge where sync_rise=1: mux_id<=sel, mux_value<=ch_values[sel] sampled that edge
//    (id and value always from the same channel, same edge); rr pointer<=sel+1, wraps
//    NUM_CH-1->0; frame_cnt<=frame_cnt+1. Outputs valid 1 cycle after sync_rise, held until next.
//  - sel (without feature) = rr pointer; first frame after reset carries ch0. NUM_CH=1: sel always 0.
//  - Watchdog: counter width clog2(TIMEOUT+1)+1. sync_rise -> counter<=0, timeout<=0 next cycle.
//    Else counter<TIMEOUT -> increment, timeout<=0; counter==TIMEOUT -> hold, timeout<=1.
//    sync_rise in same cycle counter hits TIMEOUT: rise wins, timeout stays/returns 0.
//  - timeout is sticky until the next sync_rise or rst; muxing continues regardless of timeout.
// CONFIGURATION
//  MUX_IN_CHANGE_PRIO_EN defined: per-channel shadow reg holds last value sent; changed[c] =
//    ch_values[c]!=shadow[c]. sel = first changed channel at or after rr pointer (circular
//    search); none changed -> sel=rr pointer. On send shadow[sel]<=sampled value. Shadows reset to 0.
//    Starvation bound: any channel sent at most 2*NUM_CH frames after it last changed.
//  Not defined: no shadows, pure round-robin as above; identical port list.
// STRUCTURE
//  Package rio_mux_pkg: clog2 function, WD_W derivation, FRAME_CNT_W=16 constant.
//  Sub-module rio_sync_edge (3-stage synchronizer + rising-edge pulse, clk/rst/in/rise) reused
//    by interface blocks; watchdog, selector and output regs stay in rio_mux_input.
// TESTING
//  1 rst mid-frame with mux_id=1, timeout=1 -> next cycle all outputs 0, next rise carries id 0.
//  2 NUM_CH=3, values 0x1111/0x2222/0x3333, 4 sync pulses -> ids 0,1,2,0, values match, frame_cnt=4.
//  3 sync held high 100 cycles -> exactly one sync_rise; sync pulse 1 clk wide -> still one rise.
//  4 TIMEOUT=50, no sync -> timeout rises at cycle 51 after last rise; rise at counter==50 -> stays 0.
//  5 ch1 changes 0x0005->0x0006 during rise edge -> value sampled at that edge reported, id consistent.
//  6 MUX_IN_CHANGE_PRIO_EN, NUM_CH=4, only ch3 changes, pointer=0 -> next frame id 3, then rr from 0.

Source files
------------

// File: rtl/rio_mux_pkg.sv
// Shared constants and width helpers for the rio multiplexed-input slot.
package rio_mux_pkg;

    localparam int FRAME_CNT_W = 16;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // One spare bit so the counter can hold TIMEOUT without wrapping.
    function automatic int wd_width(input int timeout);
        return clog2(timeout + 1) + 1;
    endfunction

endpackage

// File: rtl/rio_sync_edge.sv
// Three-stage synchroniser for an asynchronous level, plus a registered
// one-cycle pulse on each rising edge of the synchronised level.
module rio_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic [2:0] sync_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            rise   <= 1'b0;
        end else begin
            sync_r <= {sync_r[1:0], in};
            rise   <= (sync_r[2:1] == 2'b01);
        end
    end

endmodule

// File: rtl/rio_mux_input.sv
// Time-shares NUM_CH status values over one value/id slot of the tx frame.
// Optional MUX_IN_CHANGE_PRIO_EN: changed channels are sent ahead of round-robin.
module rio_mux_input
    import rio_mux_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int VAL_W   = 16,
    parameter int ID_W    = 8,
    parameter int TIMEOUT = 2700000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync,
    input  logic [NUM_CH*VAL_W-1:0] ch_values,
    output logic                    sync_rise,
    output logic [VAL_W-1:0]        mux_value,
    output logic [ID_W-1:0]         mux_id,
    output logic                    timeout,
    output logic [FRAME_CNT_W-1:0]  frame_cnt
);

    localparam int              WD_W    = wd_width(TIMEOUT);
    localparam logic [ID_W-1:0] LAST_CH = ID_W'(NUM_CH - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

    logic [VAL_W-1:0] ch [NUM_CH];
    logic [ID_W-1:0]  rr;
    logic [ID_W-1:0]  sel;
    logic [VAL_W-1:0] sel_value;
    logic [WD_W-1:0]  wd_cnt;

    rio_sync_edge u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (sync),
        .rise (sync_rise)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch[c] = ch_values[c*VAL_W +: VAL_W];
    end

`ifdef MUX_IN_CHANGE_PRIO_EN
    logic [VAL_W-1:0]  shadow [NUM_CH];
    logic [NUM_CH-1:0] changed;
    int                rr_i;
    int                dist;
    int                best;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chg
        assign changed[c] = (ch[c] != shadow[c]);
    end

    // Nearest changed channel in circular order from rr wins.
    always_comb begin
        sel  = rr;
        rr_i = int'(rr);
        best = NUM_CH;
        dist = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            dist = (c >= rr_i) ? (c - rr_i) : (c + NUM_CH - rr_i);
            if (changed[c] && dist < best) begin
                best = dist;
                sel  = ID_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c] <= '0;
            end
        end else if (sync_rise) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (sel == ID_W'(c)) begin
                    shadow[c] <= sel_value;
                end
            end
        end
    end
`else
    assign sel = rr;
`endif

    always_comb begin
        sel_value = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel == ID_W'(c)) begin
                sel_value = ch[c];
            end
        end
    end

    // id and value latch together so a frame never mixes channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr        <= '0;
            mux_id    <= '0;
            mux_value <= '0;
            frame_cnt <= '0;
        end else if (sync_rise) begin
            mux_id    <= sel;
            mux_value <= sel_value;
            rr        <= (sel == LAST_CH) ? '0 : sel + 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (sync_rise) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (wd_cnt < WD_MAX) begin
            wd_cnt  <= wd_cnt + 1'b1;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b1;
        end
    end

endmodule
